fpa_share_ctrl: RTL and testbench
=================================

Name: fpa_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational fpa datapath (add/multiply, IEEE-754 single) between two requesters.
- Accepts operand/operator requests over valid/ready handshakes and arbitrates round-robin.
- Holds operands stable in registers for a configurable multicycle budget, then captures number_out and returns it to the winning requester over a valid/ready response handshake.
- Sits between client logic and the fpa instance, and owns the fpa's number_A/number_B/operator inputs.

Parameters:
- CALC_CYCLES, 2, cycles operands are held on the fpa before the result is sampled; legal range 1..255.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_a  input  32  requester 0 operand A.
- req0_b  input  32  requester 0 operand B.
- req0_op  input  1  requester 0 operator; 0 = add, 1 = multiply.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 takes the result.
- rsp1_valid  output  1  result available for requester 1.
- rsp1_ready  input  1  requester 1 takes the result.
- rsp_data  output  32  result word, shared by both response channels.
- fpa_a  output  32  drives fpa number_A.
- fpa_b  output  32  drives fpa number_B.
- fpa_op  output  1  drives fpa operator.
- fpa_result  input  32  from fpa number_out.
- busy  output  1  high in any state other than IDLE.
- done_count  output  CNT_W  number of completed response handshakes; wraps to 0 after all-ones.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - last_grant=1, so requester 0 wins the first tie.
  - Operand registers, rsp_data and done_count are 0. fpa_a/fpa_b/fpa_op are 0.
  - All valid and ready outputs are 0.
  - Reset mid-operation discards the in-flight request and produces no response.
- IDLE:
  - Arbitration:
    - If exactly one reqN_valid is high, that requester wins.
    - If both are high, the requester other than last_grant wins.
  - reqN_ready is combinational and high only for the winner, only in IDLE. Accept = valid & ready in the same cycle.
  - On accept:
    - Latch a, b, op and owner into registers.
    - Load cnt=CALC_CYCLES-1.
    - Move to CALC.
  - No request: stay in IDLE; outputs hold.
- CALC:
  - fpa_a/fpa_b/fpa_op are driven from registers and stay constant for the whole state.
  - If cnt!=0: cnt decrements.
  - If cnt==0: capture fpa_result into rsp_data and move to RESP.
  - Requests are not accepted; both reqN_ready are 0.
- RESP:
  - rspN_valid is high for the owner only. rsp_data is stable until the handshake.
  - On rspN_valid & rspN_ready:
    - last_grant=owner.
    - done_count increments.
    - Move to IDLE; rspN_valid drops next cycle.
  - A stalled response (ready low) holds indefinitely. The other requester waits.
- Latency:
  - Accept edge to rspN_valid high is CALC_CYCLES+1 cycles.
  - A new accept can happen at the earliest 1 cycle after the response handshake.
  - Peak throughput is 1 operation per CALC_CYCLES+2 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Passthrough: the controller does not alter operands, operator or result bits. Special values (NaN/Inf/zero) pass through unchanged.
- rsp_data is a single register tagged by owner. The valid line of the non-owner stays 0.
- busy = (state != IDLE).

Test Plan:
- Single add: req0 a=0x3F800000, b=0x40000000, op=0, rsp0_ready=1, CALC_CYCLES=2 -> req0_ready pulses 1 cycle; rsp0_valid high exactly 3 cycles after accept; rsp_data=0x40400000; done_count=1; rsp1_valid never high.
- Tie after reset: req0 and req1 both valid from cycle 0 (req1 a=0x40000000, b=0x40400000, op=1) -> req0 granted first; req1 granted 1 cycle after rsp0 handshake; rsp1 data=0x40C00000; grants alternate over 6 back-to-back ops.
- Response stall: rsp0_ready held low 10 cycles -> rsp0_valid and rsp_data=0x40400000 stable all 10 cycles; req1_ready=0 throughout; handshake in cycle 11 then IDLE.
- Operand stability: req0_a changes every cycle after accept -> fpa_a is constant through CALC; rsp_data matches the operands latched at accept.
- Reset mid-CALC: assert rst 1 cycle after accept -> next cycle state IDLE, busy=0, rsp0_valid=0, done_count=0; no response is ever issued.
- Counter wrap with CNT_W=4: 17 completed operations -> done_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/fpa_share_ctrl.sv
// Two-requester sequencer for one shared combinational fpa datapath: round-robin
// accept, operands held for CALC_CYCLES, then the captured result is returned to the owner.
module fpa_share_ctrl #(
    parameter int CALC_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_data,
    output logic [31:0]      fpa_a,
    output logic [31:0]      fpa_b,
    output logic             fpa_op,
    input  logic [31:0]      fpa_result,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(CALC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             op_q, op_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    logic grant0, grant1, rsp_fire;

    // On a tie the requester that was not served last wins.
    assign grant0   = req0_valid && (!req1_valid || last_grant_q);
    assign grant1   = req1_valid && (!req0_valid || !last_grant_q);
    assign rsp_fire = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        done_count_d = done_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    op_d    = grant1 ? req1_op : req0_op;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rsp_data_d = fpa_result;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (rsp_fire) begin
                    last_grant_d = owner_q;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            done_count_q <= done_count_d;
        end
    end

    assign fpa_a      = a_q;
    assign fpa_b      = b_q;
    assign fpa_op     = op_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// Bench for fpa_share_ctrl: a lookup-table fpa stand-in, a negedge scoreboard monitor,
// a vector table and directed sequences for stall, tie, reset and counter wrap.
module tb_fpa_share_ctrl;

    localparam int CALC = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_op = 1'b0, req1_op = 1'b0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0]   rsp_data, fpa_a, fpa_b, fpa_result;
    logic          fpa_op, busy;
    logic [CW-1:0] done_count;

    always #5 clk = ~clk;

    fpa_share_ctrl #(.CALC_CYCLES(CALC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_op(fpa_op),
        .fpa_result(fpa_result), .busy(busy), .done_count(done_count)
    );

    // Stand-in for the fpa: exact IEEE results for the operand pairs used, an
    // asymmetric hash otherwise so swapped or corrupted operands are visible.
    function automatic logic [31:0] fpa_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b1, 32'h40000000, 32'h40400000}: return 32'h40C00000;
            {1'b0, 32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
            {1'b1, 32'h7F800000, 32'h40000000}: return 32'h7F800000;
            {1'b0, 32'h00000000, 32'h80000000}: return 32'h00000000;
            {1'b1, 32'hBF800000, 32'h40000000}: return 32'hC0000000;
            default: return (a ^ {b[15:0], b[31:16]}) + {31'b0, op};
        endcase
    endfunction

    assign fpa_result = fpa_model(fpa_a, fpa_b, fpa_op);

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb_q[$];
    logic        grants[$];
    int          total = 0, bad = 0;
    int          cyc = 0, acc_cyc = 0, hs_cyc = 0, hs_count = 0, ref_done = 0;
    logic [31:0] held_a = '0, held_b = '0;
    logic        held_op = 1'b0, prev_rv = 1'b0, gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: push on accept, pop and compare on response handshake.
    initial forever begin
        logic rv, fire, own;
        @(negedge clk);
        if (rst) begin
            sb_q.delete();
            ref_done = 0;
            prev_rv  = 1'b0;
        end else begin
            chk("done_count", {28'b0, done_count}, 32'(ref_done % 16));
            if (busy) begin
                chk("fpa_a_hold", fpa_a, held_a);
                chk("fpa_b_hold", fpa_b, held_b);
                chk("fpa_op_hold", {31'b0, fpa_op}, {31'b0, held_op});
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                chk("single_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
                own     = req1_ready;
                held_a  = own ? req1_a : req0_a;
                held_b  = own ? req1_b : req0_b;
                held_op = own ? req1_op : req0_op;
                if (gap_chk && grants.size() > 0) chk("regrant_gap", 32'(cyc - hs_cyc), 32'd1);
                grants.push_back(own);
                sb_q.push_back('{owner: own, data: fpa_model(held_a, held_b, held_op)});
                acc_cyc = cyc;
                $display("accept req%0d a=%h b=%h op=%0d cycle=%0d", own, held_a, held_b, held_op, cyc);
            end
            rv   = rsp0_valid | rsp1_valid;
            fire = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
            if (rv) begin
                if (sb_q.size() == 0) begin
                    chk("sb_depth", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("rsp_owner", {30'b0, rsp1_valid, rsp0_valid}, sb_q[0].owner ? 32'd2 : 32'd1);
                    if (!prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'(CALC + 1));
                    if (fire) begin
                        chk("rsp_data", rsp_data, sb_q[0].data);
                        $display("response rsp%0d data=%h cycle=%0d", sb_q[0].owner, rsp_data, cyc);
                        void'(sb_q.pop_front());
                        ref_done++;
                        hs_cyc = cyc;
                        hs_count++;
                    end
                end
            end
            prev_rv = rv & ~fire;
        end
    end

    task automatic send(input int r, input logic [31:0] a, input logic [31:0] b, input logic op);
        int n = 0;
        @(posedge clk); #1;
        if (r == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        do begin @(negedge clk); n++; end while (!((r == 0) ? req0_ready : req1_ready) && n < 50);
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output logic [31:0] data);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!((r == 0) ? (rsp0_valid && rsp0_ready) : (rsp1_valid && rsp1_ready)) && n < 50);
        if (n >= 50) chk("rsp_timeout", 32'(n), 32'd0);
        data = rsp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] d;
        int          n;
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        vecs[1] = '{1, 32'h40000000, 32'h40400000, 1'b1, 32'h40C00000};
        vecs[2] = '{0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000};
        vecs[3] = '{1, 32'h7F800000, 32'h40000000, 1'b1, 32'h7F800000};
        vecs[4] = '{1, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000};
        vecs[5] = '{0, 32'hBF800000, 32'h40000000, 1'b1, 32'hC0000000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fpa_a", fpa_a, 32'd0);
        chk("rst_fpa_b", fpa_b, 32'd0);
        chk("rst_fpa_op", {31'b0, fpa_op}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_valids", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_readies", {30'b0, req1_ready, req0_ready}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op);
            chk("busy_after_accept", {31'b0, busy}, 32'd1);
            wait_rsp(vecs[i].req, d);
            chk("vec_data", d, vecs[i].exp);
            @(negedge clk);
            chk("vec_done", {28'b0, done_count}, 32'(i + 1));
        end

        // Stalled response: req1 stays pending and must not be accepted.
        rsp0_ready = 1'b0;
        send(0, 32'h3F800000, 32'h40000000, 1'b0);
        req1_a = 32'h40000000; req1_b = 32'h40400000; req1_op = 1'b1; req1_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp0_valid && n < 50);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", {31'b0, rsp0_valid}, 32'd1);
            chk("stall_data", rsp_data, 32'h40400000);
            chk("stall_req1_ready", {31'b0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_stall_idle", {31'b0, busy}, 32'd0);
        chk("post_stall_accept1", {31'b0, req1_ready}, 32'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_rsp(1, d);
        chk("post_stall_data1", d, 32'h40C00000);

        // Operand stability: inputs churn after accept.
        send(0, 32'h3F800000, 32'h40000000, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            req0_a = $urandom; req0_b = $urandom; req0_op = ~req0_op;
            @(negedge clk); n++;
        end while (!rsp0_valid && n < 50);
        chk("stable_data", rsp_data, 32'h40400000);
        @(negedge clk);

        // Tie after reset: strict alternation starting with requester 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        grants.delete();
        n = hs_count;
        gap_chk = 1'b1;
        req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h40000000; req1_b = 32'h40400000; req1_op = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 200 && hs_count < n + 6; k++) @(negedge clk);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        gap_chk = 1'b0;
        chk("tie_grant_count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("tie_grant_order", {31'b0, grants[i]}, 32'(i % 2));
        @(negedge clk);

        // Reset one cycle after accept discards the operation.
        send(0, 32'h3F800000, 32'h40000000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("midrst_done", {28'b0, done_count}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // done_count wraps after all-ones.
        for (int k = 0; k < 17; k++) begin
            send(0, 32'hBF800000, 32'h40000000, 1'b1);
            wait_rsp(0, d);
            @(negedge clk);
            chk("wrap_count", {28'b0, done_count}, 32'((k + 1) % 16));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
